ds_dac_mc: RTL
==============

# ds_dac_mc

Parametrised multi-channel first-order delta-sigma DAC, successor to the single-channel 8-bit converter. It accepts signed PCM frames through a rate-limited valid/ready handshake and applies a shared soft-mute gain ramp in place of the hard hush. Each channel drives a 1-bit pulse-density output to an external RC filter or speaker pin. It sits between the allophone/sample sequencer and the board audio pins.

## Interface
- `WIDTH`, 8: sample width in bits, two's complement; legal range 4..16.
- `CHANNELS`, 1: number of independent channels; legal range 1..8.
- `OSR`, 64: clocks per accepted frame (oversampling ratio); must be ≥ 4.
- `GAIN_BITS`, 4: gain resolution. Gain runs 0..2^GAIN_BITS, where 2^GAIN_BITS is unity.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `sample` in CHANNELS*WIDTH: frame. Channel c occupies `[c*WIDTH +: WIDTH]`, signed.
- `sample_valid` in 1: frame present.
- `sample_ready` out 1: block accepts a frame this cycle.
- `hush` in 1: request mute; level-sensitive.
- `speaker` out CHANNELS: registered pulse-density outputs.
- `muted` out 1: high while the FSM is in MUTED.

## Operation
- Frame counter `fcnt` counts 0..OSR-1 and wraps. `tick` = (`fcnt`==OSR-1).
- `sample_ready` = `tick`. A frame is accepted when `sample_valid && sample_ready`, and loads the per-channel hold registers.
- With no valid frame on a tick, the hold registers keep their last frame. There is no underflow flag.
- Gain FSM. Gain register `g` is GAIN_BITS+1 wide. The FSM advances only on `tick`.
  - PLAY: `g`=2^GAIN_BITS. `hush`=1 → FADE_OUT.
  - FADE_OUT: `g`-=1 per tick. Reaching 0 → MUTED. `hush`=0 → FADE_IN, continuing from the current `g`.
  - MUTED: `g`=0. `hush`=0 → FADE_IN.
  - FADE_IN: `g`+=1 per tick. Reaching 2^GAIN_BITS → PLAY. `hush`=1 → FADE_OUT from the current `g`.
- Scaling, per channel: `scaled` = (hold × `g`) >>> GAIN_BITS. This is a signed multiply followed by an arithmetic shift. The result is truncated to WIDTH bits and cannot overflow because `g` ≤ unity. `scaled` is registered.
- Offset conversion: `u` = `scaled` + 2^(WIDTH-1), computed modulo 2^WIDTH. Full-scale negative maps to 0.
- Modulator, per channel:
  - `acc` is WIDTH+1 bits.
  - Next `acc` = {1'b0, `acc`[WIDTH-1:0]} + `u` + `cin`.
  - `speaker[c]` = registered `acc`[WIDTH].
  - Long-run duty is `u`/2^WIDTH.
- All channels share the FSM, `g`, `fcnt` and the handshake.

## Timing
- Reset values:
  - `fcnt`=0, FSM=MUTED, `g`=0.
  - Hold and `scaled` registers = 0.
  - `acc` = 2^(WIDTH-1).
  - `speaker`=0, `muted`=1, `sample_ready`=0.
- After reset with `hush`=0, FADE_IN begins on the first tick. Unity gain is reached after 2^GAIN_BITS further ticks.
- Latency:
  - Frame accepted at edge T.
  - `scaled` is updated at T+1 using the `g` in effect at T+1.
  - `acc`/`speaker` first reflect the new value at T+2.
- A gain change on a tick affects `scaled` from the next edge onward.
- `hush` is sampled only on ticks. Pulses shorter than OSR cycles between ticks are ignored.
- When a tick coincides with an FSM boundary (`g` reaching 0 or unity) and a `hush` change, the boundary transition wins. The new `hush` level is evaluated on the next tick.
- `rst` asserted mid-fade or mid-frame returns all state to reset values on that edge. A frame offered in the same cycle as `rst` is dropped.

## Configuration
- `DS_DAC_MC_DITHER_EN` defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every clk.
  - `cin` = LFSR bit `c` mod 16 for channel c, which breaks idle tones.
- Not defined: `cin`=0, no LFSR is instantiated, and outputs are fully deterministic.
- The test plan assumes the macro is undefined unless stated.

## Test plan
- Idle tone: WIDTH=8, CHANNELS=1, `hush`=0, frame 8'h00 held.
  - Required: after ramp completes, `speaker` alternates 1,0 every clk.
- Full scale: frame 8'h7F at unity gain.
  - Required: `speaker` high 255 of every 256 clks.
  - Frame 8'h80: `speaker` constantly 0.
- Handshake: `sample_valid` held high with a new frame each cycle, OSR=64.
  - Required: `sample_ready` pulses exactly once per 64 clks, and only the frames coinciding with those pulses are captured.
- Fade: frame 8'h40 at PLAY, `hush`=1.
  - Required: `g` falls 16→0 over 16 ticks, `muted` rises on the tick `g` reaches 0, and `speaker` duty settles at 50%.
  - Release `hush` at `g`=8: `g` climbs 8→16 without passing through MUTED.
- Multi-channel: CHANNELS=2, WIDTH=12, frames ch0=12'h400, ch1=12'hC00.
  - Required: duty 75% and 25% respectively.
  - `rst` pulse mid-fade: `muted`=1 and `speaker`=2'b00 on the following cycle.
- With `DS_DAC_MC_DITHER_EN`: frame 8'h00.
  - Required: duty over 4096 clks is within 50% ± 1%, and the output is not strictly alternating.

Source files
------------

// File: rtl/ds_dac_mc.sv
// ============================================================================
// Module   : ds_dac_mc
// Purpose  : Multi-channel first-order delta-sigma DAC with a shared
//            soft-mute gain ramp. Signed PCM frames are accepted once per
//            OSR clocks through a valid/ready handshake, scaled by a common
//            gain, offset to unsigned and converted to 1-bit pulse-density
//            outputs.
// Ports    : clk          - system clock
//            rst          - synchronous active-high reset
//            sample       - CHANNELS*WIDTH frame, channel c at [c*WIDTH +: WIDTH]
//            sample_valid - frame present
//            sample_ready - frame accepted this cycle when valid is high
//            hush         - level-sensitive mute request, sampled on ticks
//            speaker      - registered pulse-density outputs, one per channel
//            muted        - high while the gain FSM is in MUTED
// Options  : DS_DAC_MC_DITHER_EN - when defined, a 16-bit Galois LFSR feeds
//            the modulator carry-in to break up idle tones.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

module ds_dac_mc #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 1,
    parameter int OSR       = 64,
    parameter int GAIN_BITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS*WIDTH-1:0]  sample,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic                       hush,
    output logic [CHANNELS-1:0]        speaker,
    output logic                       muted
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_FCW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int c_GW  = GAIN_BITS + 1;
    // Product width: WIDTH-bit signed sample times a (GAIN_BITS+2)-bit
    // non-negative signed gain.
    localparam int c_PW  = WIDTH + GAIN_BITS + 2;

    localparam logic [c_FCW-1:0] c_FLAST    = c_FCW'(OSR - 1);
    localparam logic [c_GW-1:0]  c_UNITY    = {1'b1, {GAIN_BITS{1'b0}}};
    localparam logic [c_GW-1:0]  c_UNITY_M1 = {1'b0, {GAIN_BITS{1'b1}}};
    localparam logic [c_GW-1:0]  c_GONE     = {{(c_GW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   c_ACC_INIT = {2'b01, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] c_S_PLAY     = 2'd0;
    localparam logic [1:0] c_S_FADE_OUT = 2'd1;
    localparam logic [1:0] c_S_MUTED    = 2'd2;
    localparam logic [1:0] c_S_FADE_IN  = 2'd3;

    // ------------------------------------------------------------------------
    // Frame counter and handshake
    // ------------------------------------------------------------------------
    logic [c_FCW-1:0] r_fcnt;
    logic             w_tick;
    logic             w_accept;

    assign w_tick       = (r_fcnt == c_FLAST);
    assign sample_ready = w_tick;
    assign w_accept     = sample_valid && w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt <= '0;
        end else if (w_tick) begin
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + c_FCW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Gain FSM
    // Boundary transitions (gain reaching 0 or unity) take priority over a
    // hush change on the same tick; the new hush level is then seen on the
    // following tick. Turning around mid-fade keeps the current gain.
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_GW-1:0] r_g;
    logic [c_GW-1:0] w_g_nxt;
    logic            r_muted;

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        if (w_tick) begin
            case (r_state)
                c_S_PLAY: begin
                    w_g_nxt = c_UNITY;
                    if (hush) begin
                        w_state_nxt = c_S_FADE_OUT;
                    end
                end
                c_S_FADE_OUT: begin
                    // A fade-out entered straight from gain 0 also lands here.
                    if (r_g <= c_GONE) begin
                        w_g_nxt     = '0;
                        w_state_nxt = c_S_MUTED;
                    end else if (!hush) begin
                        w_state_nxt = c_S_FADE_IN;
                    end else begin
                        w_g_nxt = r_g - c_GONE;
                    end
                end
                c_S_MUTED: begin
                    w_g_nxt = '0;
                    if (!hush) begin
                        w_state_nxt = c_S_FADE_IN;
                    end
                end
                c_S_FADE_IN: begin
                    if (r_g >= c_UNITY_M1) begin
                        w_g_nxt     = c_UNITY;
                        w_state_nxt = c_S_PLAY;
                    end else if (hush) begin
                        w_state_nxt = c_S_FADE_OUT;
                    end else begin
                        w_g_nxt = r_g + c_GONE;
                    end
                end
                default: begin
                    w_g_nxt     = '0;
                    w_state_nxt = c_S_MUTED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_MUTED;
            r_g     <= '0;
            r_muted <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;
            r_muted <= (w_state_nxt == c_S_MUTED);
        end
    end

    assign muted = r_muted;

    // ------------------------------------------------------------------------
    // Modulator carry-in source
    // ------------------------------------------------------------------------
    logic [CHANNELS-1:0] w_cin;

`ifdef DS_DAC_MC_DITHER_EN
    logic [15:0] r_lfsr;

    // Right-shifting Galois LFSR, taps 16,14,13,11.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_cin
        assign w_cin[c] = r_lfsr[c % 16];
    end
`else
    assign w_cin = '0;
`endif

    // ------------------------------------------------------------------------
    // Per-channel datapath: hold -> scale -> offset -> modulate
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0]        r_hold;
        logic [WIDTH-1:0]        r_scaled;
        logic [WIDTH:0]          r_acc;
        logic signed [c_PW-1:0]  w_hold_ext;
        logic signed [c_PW-1:0]  w_g_ext;
        logic signed [c_PW-1:0]  w_prod;
        logic [WIDTH-1:0]        w_u;
        logic [WIDTH:0]          w_acc_nxt;
        logic                    w_unused_prod;

        assign w_hold_ext = {{(c_PW-WIDTH){r_hold[WIDTH-1]}}, r_hold};
        assign w_g_ext    = {{(c_PW-c_GW){1'b0}}, r_g};
        assign w_prod     = w_hold_ext * w_g_ext;

        // Taking bits [GAIN_BITS +: WIDTH] is the arithmetic shift right by
        // GAIN_BITS followed by truncation; gain never exceeds unity, so the
        // dropped top bits are pure sign extension.
        assign w_unused_prod = ^{w_prod[c_PW-1 -: 2], w_prod[GAIN_BITS-1:0]};

        // Adding 2^(WIDTH-1) modulo 2^WIDTH only flips the sign bit.
        assign w_u = {~r_scaled[WIDTH-1], r_scaled[WIDTH-2:0]};

        assign w_acc_nxt = {1'b0, r_acc[WIDTH-1:0]}
                         + {1'b0, w_u}
                         + {{WIDTH{1'b0}}, w_cin[c]};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_hold   <= '0;
                r_scaled <= '0;
                r_acc    <= c_ACC_INIT;
            end else begin
                if (w_accept) begin
                    r_hold <= sample[c*WIDTH +: WIDTH];
                end
                r_scaled <= w_prod[GAIN_BITS +: WIDTH];
                r_acc    <= w_acc_nxt;
            end
        end

        // The accumulator carry bit is the registered pulse-density output.
        assign speaker[c] = r_acc[WIDTH];
    end

endmodule

`default_nettype wire
